pe_loopback_engine: RTL and testbench
=====================================

PE_LOOPBACK_ENGINE -- requirements
Module: pe_loopback_engine

Interface
REQ-001 SHALL have parameter TBB_DATA_WIDTH, default 32, meaning the TBB read-data width.
REQ-002 SHALL have parameter TBB_ADDR_WIDTH, default 16, meaning the TBB address width.
REQ-003 SHALL have parameter RBB_DATA_WIDTH, default 32, meaning the RBB write-data width.
REQ-004 SHALL have parameter RBB_ADDR_WIDTH, default 12, meaning the RBB address width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port bm2pe_start, input, 1 bit: run request.
REQ-008 SHALL have port bm2pe_mode, input, 2 bits: write-data pattern select.
REQ-009 SHALL have port bm2pe_rdCount, input, TBB_ADDR_WIDTH bits: number of reads minus 1.
REQ-010 SHALL have port bm2pe_wrCount, input, RBB_ADDR_WIDTH bits: number of writes minus 1.
REQ-011 SHALL have port pe2bm_tbbRdAddr, output, TBB_ADDR_WIDTH bits: TBB read address.
REQ-012 SHALL have port bm2pe_tbbRdDout, input, TBB_DATA_WIDTH bits: TBB read data, valid one cycle after its address.
REQ-013 SHALL have port pe2bm_rbbWrEn, output, 1 bit: RBB write strobe.
REQ-014 SHALL have port pe2bm_rbbWrAddr, output, RBB_ADDR_WIDTH bits: RBB write address.
REQ-015 SHALL have port pe2bm_rbbWrDin, output, RBB_DATA_WIDTH bits: RBB write data.
REQ-016 SHALL have port pe2bm_busy, output, 1 bit: high in any state other than IDLE.
REQ-017 SHALL have port pe2bm_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-018 SHALL implement the states IDLE, READ, DRAIN, WRITE and DONE; all outputs are registered.
REQ-019 SHALL, in IDLE, on bm2pe_start=1, capture mode, rdCount and wrCount, clear the checksum, and enter READ the following cycle.
REQ-020 SHALL ignore bm2pe_start in every state except IDLE.
REQ-021 SHALL, in READ, drive pe2bm_tbbRdAddr = 0,1,...,rdCount on consecutive cycles (rdCount+1 cycles), then enter DRAIN.
REQ-022 SHALL accumulate checksum = XOR of the bm2pe_tbbRdDout values returned for addresses 0..rdCount, using a one-cycle-delayed valid; DRAIN (one cycle) captures the last word.
REQ-023 SHALL, in WRITE, assert pe2bm_rbbWrEn for exactly wrCount+1 consecutive cycles with pe2bm_rbbWrAddr = 0..wrCount.
REQ-024 SHALL select write data by the captured mode, where i is the write index: 0: i zero-extended; 1: constant 32'hDEADBEEF; 2: checksum; 3: checksum XOR i.
REQ-025 SHALL zero-extend or truncate all write data to RBB_DATA_WIDTH.
REQ-026 SHALL enter DONE after the last write, pulse pe2bm_done for one cycle, then return to IDLE.
REQ-027 SHALL produce pe2bm_done exactly rdCount+wrCount+4 cycles after the edge that samples bm2pe_start.
REQ-028 SHALL hold pe2bm_tbbRdAddr at 0 outside READ, and hold pe2bm_rbbWrAddr and pe2bm_rbbWrDin at 0 whenever pe2bm_rbbWrEn=0.
REQ-029 SHALL support maximum counts (all-ones) without counter wrap: 2^TBB_ADDR_WIDTH reads and 2^RBB_ADDR_WIDTH writes.
REQ-030 SHALL, when a count is 0, perform exactly one read or one write respectively.

Reset
REQ-031 SHALL, on reset_n=0 at any time, immediately force IDLE, clear the checksum, and drive all outputs to 0, including mid-READ and mid-WRITE.
REQ-032 SHALL NOT accept bm2pe_start in the cycle in which reset_n deasserts.

Configuration
REQ-033 SHALL, with macro PE_LOOPBACK_CKSUM_EN defined, implement the checksum as specified above.
REQ-034 SHALL, without PE_LOOPBACK_CKSUM_EN, hold the checksum at constant 0, so that mode 2 writes 0 and mode 3 writes i; READ and DRAIN timing is unchanged.

Verification
REQ-035 SHALL cover: mode 0, rdCount=3, wrCount=7 -> RBB[0..7] = 0..7; pe2bm_done 14 cycles after start; busy is high throughout.
REQ-036 SHALL cover: TBB[0..3] = 1, 2, 4, 8, mode 2, rdCount=3, wrCount=1, with CKSUM_EN -> RBB[0..1] = 0xF; without CKSUM_EN -> RBB[0..1] = 0.
REQ-037 SHALL cover: mode 1, rdCount=wrCount=all-ones (default widths) -> 65536 reads, 4096 writes of 0xDEADBEEF, and no extra or missing strobes.
REQ-038 SHALL cover: bm2pe_start re-pulsed during READ and during DONE -> ignored; exactly one done pulse.
REQ-039 SHALL cover: reset_n pulsed low at write index 5 -> outputs 0 immediately; a new start afterwards runs cleanly from address 0.
REQ-040 SHALL cover: mode 3, TBB[0]=0xA5, rdCount=0, wrCount=2 -> RBB[0..2] = 0xA5, 0xA4, 0xA7.

Source files
------------

// File: rtl/pe_loopback_engine.sv
// rtl/pe_loopback_engine.sv - TBB read sweep, XOR checksum, patterned RBB write sweep
// Optional feature: define PE_LOOPBACK_CKSUM_EN to accumulate the read checksum (else it stays 0).
module pe_loopback_engine #(
  parameter int TBB_DATA_WIDTH = 32,
  parameter int TBB_ADDR_WIDTH = 16,
  parameter int RBB_DATA_WIDTH = 32,
  parameter int RBB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      bm2pe_start,
  input  logic [1:0]                bm2pe_mode,
  input  logic [TBB_ADDR_WIDTH-1:0] bm2pe_rdCount,
  input  logic [RBB_ADDR_WIDTH-1:0] bm2pe_wrCount,
  output logic [TBB_ADDR_WIDTH-1:0] pe2bm_tbbRdAddr,
  input  logic [TBB_DATA_WIDTH-1:0] bm2pe_tbbRdDout,
  output logic                      pe2bm_rbbWrEn,
  output logic [RBB_ADDR_WIDTH-1:0] pe2bm_rbbWrAddr,
  output logic [RBB_DATA_WIDTH-1:0] pe2bm_rbbWrDin,
  output logic                      pe2bm_busy,
  output logic                      pe2bm_done
);
  localparam int CW  = (TBB_ADDR_WIDTH > RBB_ADDR_WIDTH) ? TBB_ADDR_WIDTH : RBB_ADDR_WIDTH;
  localparam int XW0 = (TBB_DATA_WIDTH > 32) ? TBB_DATA_WIDTH : 32;
  localparam int XW1 = (RBB_DATA_WIDTH > XW0) ? RBB_DATA_WIDTH : XW0;
  localparam int XW  = (CW > XW1) ? CW : XW1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             idx_q, idx_d;
  logic [1:0]                mode_q, mode_d;
  logic [TBB_ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [RBB_ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [TBB_DATA_WIDTH-1:0] cksum_q, cksum_d, cksum_fwd;
  logic                      armed_q, addr_vld_q, data_vld_q;
  logic [TBB_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                      wr_en_q, wr_en_d;
  logic [RBB_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [RBB_DATA_WIDTH-1:0] wr_din_q, wr_din_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic [XW-1:0]             wr_pattern;

  // Forwarded checksum so the first write already sees the word landing this cycle.
`ifdef PE_LOOPBACK_CKSUM_EN
  assign cksum_fwd = data_vld_q ? (cksum_q ^ bm2pe_tbbRdDout) : cksum_q;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^{bm2pe_tbbRdDout, data_vld_q};
  assign cksum_fwd      = cksum_q;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
`ifdef PE_LOOPBACK_CKSUM_EN
    cksum_d  = cksum_fwd;
`else
    cksum_d  = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bm2pe_start && armed_q) begin
          mode_d   = bm2pe_mode;
          rd_cnt_d = bm2pe_rdCount;
          wr_cnt_d = bm2pe_wrCount;
          cksum_d  = '0;
          idx_d    = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (idx_q == CW'(rd_cnt_q)) begin
          idx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if (idx_q == CW'(wr_cnt_q)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_pattern = '0;
    unique case (mode_q)
      2'd0:    wr_pattern = XW'(idx_q);
      2'd1:    wr_pattern = XW'(32'hDEADBEEF);
      2'd2:    wr_pattern = XW'(cksum_fwd);
      default: wr_pattern = XW'(cksum_fwd) ^ XW'(idx_q);
    endcase
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_din_d  = '0;
    if (state_q == S_READ) rd_addr_d = idx_q[TBB_ADDR_WIDTH-1:0];
    if (state_q == S_WRITE) begin
      wr_en_d   = 1'b1;
      wr_addr_d = idx_q[RBB_ADDR_WIDTH-1:0];
      wr_din_d  = wr_pattern[RBB_DATA_WIDTH-1:0];
    end
    done_d = (state_q == S_DONE);
    // busy covers the start edge through the done pulse
    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mode_q     <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      cksum_q    <= '0;
      armed_q    <= 1'b0;
      addr_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_din_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      cksum_q    <= cksum_d;
      armed_q    <= 1'b1;
      addr_vld_q <= (state_q == S_READ);
      data_vld_q <= addr_vld_q;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_din_q   <= wr_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pe2bm_tbbRdAddr = rd_addr_q;
  assign pe2bm_rbbWrEn   = wr_en_q;
  assign pe2bm_rbbWrAddr = wr_addr_q;
  assign pe2bm_rbbWrDin  = wr_din_q;
  assign pe2bm_busy      = busy_q;
  assign pe2bm_done      = done_q;
endmodule

// File: tb/tb_pe_loopback_engine.sv
// tb/tb_pe_loopback_engine.sv - directed and random runs of pe_loopback_engine against a transaction-level model
// Honours PE_LOOPBACK_CKSUM_EN the same way as the design.
module tb_pe_loopback_engine;
  logic        clk, reset_n, start;
  logic [1:0]  mode;
  logic [15:0] rdc, tbb_addr;
  logic [11:0] wrc, wr_addr;
  logic [31:0] tbb_dout, wr_din;
  logic        wr_en, busy, done;

  logic [31:0] tbb_mem [0:65535];
  logic [31:0] wr_log  [0:7];
  int          n_vec, n_err;

  pe_loopback_engine dut (
    .clk(clk), .reset_n(reset_n), .bm2pe_start(start), .bm2pe_mode(mode),
    .bm2pe_rdCount(rdc), .bm2pe_wrCount(wrc), .pe2bm_tbbRdAddr(tbb_addr),
    .bm2pe_tbbRdDout(tbb_dout), .pe2bm_rbbWrEn(wr_en), .pe2bm_rbbWrAddr(wr_addr),
    .pe2bm_rbbWrDin(wr_din), .pe2bm_busy(busy), .pe2bm_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous TBB: data appears the cycle after its address
  always @(posedge clk) tbb_dout <= tbb_mem[tbb_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [1:0] m, input int i, input logic [31:0] ck);
    case (m)
      2'd0:    return 32'(i);
      2'd1:    return 32'hDEADBEEF;
      2'd2:    return ck;
      default: return ck ^ 32'(i);
    endcase
  endfunction

  task automatic run_op(input logic [1:0] m, input int rd, input int wr, input bit repulse);
    int cyc, lat, limit, n_done, n_busy_lo, n_rd_nz, rd_bad, n_wr, n_burst, wr_bad;
    logic        prev_en;
    logic [15:0] prev_ra;
    logic [31:0] ck;
    ck = 32'd0;
`ifdef PE_LOOPBACK_CKSUM_EN
    for (int k = 0; k <= rd; k++) ck ^= tbb_mem[k];
`endif
    cyc = 0; lat = -1; limit = rd + wr + 30;
    n_done = 0; n_busy_lo = 0; n_rd_nz = 0; rd_bad = 0; n_wr = 0; n_burst = 0; wr_bad = 0;
    prev_en = 1'b0; prev_ra = 16'd0;
    @(negedge clk);
    start = 1'b1; mode = m; rdc = 16'(rd); wrc = 12'(wr);
    while (cyc <= limit) begin
      @(negedge clk);
      start = repulse && (cyc == 1 || cyc == rd + wr + 3);
      if (done === 1'b1) begin
        n_done++;
        if (lat < 0) begin lat = cyc; limit = cyc + 4; end
      end
      if ((lat < 0 || cyc == lat) && busy !== 1'b1) n_busy_lo++;
      if (tbb_addr !== 16'd0) begin
        n_rd_nz++;
        if (tbb_addr !== prev_ra + 16'd1) rd_bad++;
      end
      prev_ra = tbb_addr;
      if (wr_en === 1'b1) begin
        if (!prev_en) n_burst++;
        if (wr_addr !== 12'(n_wr) || wr_din !== exp_word(m, n_wr, ck)) wr_bad++;
        if (n_wr < 8) wr_log[n_wr] = wr_din;
        n_wr++;
      end else if (wr_addr !== 12'd0 || wr_din !== 32'd0) begin
        wr_bad++;
      end
      prev_en = (wr_en === 1'b1);
      cyc++;
    end
    check("done_latency", 64'(lat), 64'(rd + wr + 4));
    check("done_pulses", 64'(n_done), 64'd1);
    check("busy_low_while_running", 64'(n_busy_lo), 64'd0);
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("read_nonzero_addrs", 64'(n_rd_nz), 64'(rd));
    check("read_addr_sequence", 64'(rd_bad), 64'd0);
    check("write_strobes", 64'(n_wr), 64'(wr + 1));
    check("write_bursts", 64'(n_burst), 64'd1);
    check("write_addr_data", 64'(wr_bad), 64'd0);
  endtask

  initial begin
    bit found;
    logic [31:0] ck_on;
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; start = 1'b0; mode = 2'd0; rdc = 16'd0; wrc = 12'd0;
    for (int k = 0; k < 65536; k++) tbb_mem[k] = $urandom;
    ck_on = 32'd0;
`ifdef PE_LOOPBACK_CKSUM_EN
    ck_on = 32'hFFFF_FFFF;
`endif
    #2;
    check("reset_rd_addr", 64'(tbb_addr), 64'd0);
    check("reset_wr_en", {63'd0, wr_en}, 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_wr_din", 64'(wr_din), 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op(2'd0, 3, 7, 1'b0);
    for (int i = 0; i < 8; i++) check("mode0_data", 64'(wr_log[i]), 64'(i));

    tbb_mem[0] = 32'd1; tbb_mem[1] = 32'd2; tbb_mem[2] = 32'd4; tbb_mem[3] = 32'd8;
    run_op(2'd2, 3, 1, 1'b0);
    check("mode2_cksum_w0", 64'(wr_log[0]), 64'(32'hF & ck_on));
    check("mode2_cksum_w1", 64'(wr_log[1]), 64'(32'hF & ck_on));

    tbb_mem[0] = 32'hA5;
    run_op(2'd3, 0, 2, 1'b0);
    check("mode3_w0", 64'(wr_log[0]), 64'((32'hA5 & ck_on) ^ 32'd0));
    check("mode3_w1", 64'(wr_log[1]), 64'((32'hA5 & ck_on) ^ 32'd1));
    check("mode3_w2", 64'(wr_log[2]), 64'((32'hA5 & ck_on) ^ 32'd2));

    run_op(2'd3, 5, 6, 1'b1);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 64; k++) tbb_mem[k] = $urandom;
      run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 50)),
             int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk); start = 1'b1; mode = 2'd0; rdc = 16'd2; wrc = 12'd9;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (wr_en === 1'b1 && wr_addr === 12'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_write_idx5", {63'd0, found}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_rd_addr", 64'(tbb_addr), 64'd0);
    check("midrst_wr_en", {63'd0, wr_en}, 64'd0);
    check("midrst_wr_addr", 64'(wr_addr), 64'd0);
    check("midrst_wr_din", 64'(wr_din), 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    @(negedge clk); reset_n = 1'b1; start = 1'b1; rdc = 16'd0; wrc = 12'd0;
    @(negedge clk);
    check("start_at_reset_release", {63'd0, busy}, 64'd0);
    start = 1'b0;
    run_op(2'd0, 2, 4, 1'b0);

    run_op(2'd1, 65535, 4095, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
